mul_arbiter: RTL and testbench

- Shares the single 8x8 signed Booth multiplier between two requesters: port 0 is the ALU MUL path and port 1 is the address/index unit.
- Arbitrates round-robin and drives the multiplier's enable and operand inputs.
- Sequences the multiplier through load (en low) and run (en high until ready).
- Captures the 16-bit product and returns it to the winning requester with a one-cycle done pulse.
- Includes a timeout so a hung multiplier cannot lock the bus.

---
 rtl/mul_arbiter_if.sv | 35 +++
 rtl/mul_arbiter.sv | 128 ++++++++++++
 tb/tb_mul_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_arbiter_if.sv
// Requester and multiplier-side signals shared between the multiplier arbiter and its environment.
interface mul_arbiter_if;
  localparam int unsigned OW = 8;
  localparam int unsigned PW = 16;

  logic          req0;
  logic [OW-1:0] a0;
  logic [OW-1:0] b0;
  logic          req1;
  logic [OW-1:0] a1;
  logic [OW-1:0] b1;
  logic          done0;
  logic          done1;
  logic [PW-1:0] result0;
  logic [PW-1:0] result1;
  logic          err;
  logic          busy;
  logic          mul_en;
  logic [OW-1:0] mul_a;
  logic [OW-1:0] mul_b;
  logic [PW-1:0] mul_out;
  logic          mul_ready;

  // Environment side: requesters plus the shared multiplier
  modport master (
    output req0, a0, b0, req1, a1, b1, mul_out, mul_ready,
    input  done0, done1, result0, result1, err, busy, mul_en, mul_a, mul_b
  );

  // Arbiter side
  modport slave (
    input  req0, a0, b0, req1, a1, b1, mul_out, mul_ready,
    output done0, done1, result0, result1, err, busy, mul_en, mul_a, mul_b
  );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one 8x8 signed multiplier between two requesters,
// sequencing load/run phases and aborting a run that exceeds TIMEOUT cycles.
module mul_arbiter #(
  parameter int unsigned TIMEOUT = 32,
  parameter int unsigned CW      = 6
) (
  input logic          clk,
  input logic          reset,
  mul_arbiter_if.slave bus
);
  localparam int unsigned OW = 8;
  localparam int unsigned PW = 16;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          grant;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] mul_a_q, mul_a_d;
  logic [OW-1:0] mul_b_q, mul_b_d;
  logic [PW-1:0] result0_q, result0_d;
  logic [PW-1:0] result1_q, result1_d;
  logic          mul_en_q, mul_en_d;
  logic          done0_q, done0_d;
  logic          done1_q, done1_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      result0_q <= '0;
      result1_q <= '0;
      mul_en_q  <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      result0_q <= result0_d;
      result1_q <= result1_d;
      mul_en_q  <= mul_en_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    grant     = 1'b0;
    cnt_d     = cnt_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    result0_d = result0_q;
    result1_d = result1_q;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // On a tie the port that did not win last time goes next
          grant   = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
          owner_d = grant;
          last_d  = grant;
          mul_a_d = grant ? bus.a1 : bus.a0;
          mul_b_d = grant ? bus.b1 : bus.b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        // mul_ready in the first RUN cycle may be left over from the previous job
        if ((cnt_q != '0) && bus.mul_ready) begin
          if (owner_q) result1_d = bus.mul_out;
          else         result0_d = bus.mul_out;
          state_d = DONE;
        end else if (cnt_d == CW'(TIMEOUT)) begin
          if (owner_q) result1_d = '0;
          else         result0_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    mul_en_d = (state_d == RUN);
    busy_d   = (state_d != IDLE);
    done0_d  = (state_d == DONE) && !owner_d;
    done1_d  = (state_d == DONE) && owner_d;
  end

  assign bus.mul_en  = mul_en_q;
  assign bus.mul_a   = mul_a_q;
  assign bus.mul_b   = mul_b_q;
  assign bus.result0 = result0_q;
  assign bus.result1 = result1_q;
  assign bus.done0   = done0_q;
  assign bus.done1   = done1_q;
  assign bus.err     = err_q;
  assign bus.busy    = busy_q;
endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of grant order, latency and products.
module tb_mul_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mul_arbiter_if bus();
  mul_arbiter #(.TIMEOUT(32), .CW(6)) dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Multiplier stub: ready lat enabled cycles after enable, or never when hung
  int   lat   = 1;
  logic hang  = 1'b0;
  logic stale = 1'b0;
  int   stub_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stub_cnt      <= 0;
      bus.mul_ready <= 1'b0;
      bus.mul_out   <= 16'h0;
    end else if (!bus.mul_en) begin
      stub_cnt      <= 0;
      bus.mul_ready <= stale;
      bus.mul_out   <= stale ? 16'hDEAD : 16'h0;
    end else begin
      stub_cnt <= stub_cnt + 1;
      if (!hang && (stub_cnt + 1 >= lat)) begin
        bus.mul_ready <= 1'b1;
        bus.mul_out   <= 16'(int'($signed(bus.mul_a)) * int'($signed(bus.mul_b)));
      end else begin
        bus.mul_ready <= 1'b0;
        bus.mul_out   <= 16'hBEEF;
      end
    end
  end

  // Reference model state
  logic        m_last;
  logic [15:0] m_r0, m_r1;

  function automatic logic [15:0] prod(input logic [7:0] a, input logic [7:0] b);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return 16'(sa * sb);
  endfunction

  task automatic wait_done(output int n, output int en_cnt, output int first_en);
    n = 0; en_cnt = 0; first_en = 0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (bus.mul_en) begin
        en_cnt++;
        if (first_en == 0) first_en = n;
      end
      if (bus.done0 || bus.done1) break;
    end
  endtask

  task automatic test_reset();
    logic [60:0] outs;
    bus.req0 = 0; bus.req1 = 0;
    bus.a0 = 0; bus.b0 = 0; bus.a1 = 0; bus.b1 = 0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    outs = {bus.done0, bus.done1, bus.err, bus.busy, bus.mul_en, bus.mul_a, bus.mul_b,
            bus.result0, bus.result1};
    total++;
    if (outs !== 61'd0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", outs); end
    reset = 1'b0;
    @(negedge clk);
    m_last = 1'b1; m_r0 = 16'h0; m_r1 = 16'h0;
  endtask

  task automatic test_single();
    int n, en, fe;
    lat = 1; hang = 0; stale = 0;
    bus.a0 = 8'd7; bus.b0 = 8'd6; bus.req0 = 1;
    wait_done(n, en, fe);
    total++;
    if (n !== 4) begin bad++; $display("FAIL single_latency got=%0d exp=4", n); end
    total++;
    if ({bus.done1, bus.done0, bus.err} !== 3'b010) begin
      bad++; $display("FAIL single_done got=%b exp=010", {bus.done1, bus.done0, bus.err});
    end
    total++;
    if (bus.result0 !== 16'h002A) begin bad++; $display("FAIL single_result got=%h exp=002a", bus.result0); end
    total++;
    if (en !== 2 || fe !== 2) begin bad++; $display("FAIL single_en_window got=%0d/%0d exp=2/2", en, fe); end
    bus.req0 = 0;
    @(negedge clk);
    total++;
    if ({bus.busy, bus.mul_en, bus.done0} !== 3'b000) begin
      bad++; $display("FAIL single_idle got=%b exp=000", {bus.busy, bus.mul_en, bus.done0});
    end
    m_last = 1'b0; m_r0 = 16'h002A;
  endtask

  task automatic test_signed();
    int n, en, fe;
    lat = 3;
    bus.a1 = 8'hFD; bus.b1 = 8'd5; bus.req1 = 1;
    wait_done(n, en, fe);
    total++;
    if (n !== 6 || bus.done1 !== 1'b1 || bus.done0 !== 1'b0) begin
      bad++; $display("FAIL signed_done got=n%0d d1=%b d0=%b exp=n6 d1=1 d0=0", n, bus.done1, bus.done0);
    end
    total++;
    if (bus.result1 !== 16'hFFF1 || bus.result0 !== m_r0) begin
      bad++; $display("FAIL signed_result got=%h/%h exp=fff1/%h", bus.result1, bus.result0, m_r0);
    end
    bus.req1 = 0;
    @(negedge clk);
    m_last = 1'b1; m_r1 = 16'hFFF1;
  endtask

  task automatic test_simultaneous();
    int n, en, fe;
    logic win;
    reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
    m_last = 1'b1; m_r0 = 16'h0; m_r1 = 16'h0;
    lat = 2;
    bus.a0 = 8'd2; bus.b0 = 8'd3; bus.a1 = 8'd4; bus.b1 = 8'd5;
    bus.req0 = 1; bus.req1 = 1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL simul_idle_gap op=%0d got=%b exp=0", k, bus.busy); end
      end
      wait_done(n, en, fe);
      win = ~m_last;
      m_last = win;
      if (win) m_r1 = prod(bus.a1, bus.b1); else m_r0 = prod(bus.a0, bus.b0);
      total++;
      if (n !== 5 || {bus.done1, bus.done0} !== (win ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL simul_grant op=%0d got=n%0d done=%b exp=n5 port%0d", k, n, {bus.done1, bus.done0}, win);
      end
      total++;
      if (bus.result0 !== m_r0 || bus.result1 !== m_r1) begin
        bad++; $display("FAIL simul_result op=%0d got=%h/%h exp=%h/%h", k, bus.result0, bus.result1, m_r0, m_r1);
      end
    end
    bus.req0 = 0; bus.req1 = 0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int n, en, fe;
    hang = 1;
    bus.a0 = 8'h11; bus.b0 = 8'h22; bus.req0 = 1;
    wait_done(n, en, fe);
    total++;
    if (n !== 34 || en !== 32) begin bad++; $display("FAIL timeout_cycles got=n%0d en%0d exp=n34 en32", n, en); end
    total++;
    if ({bus.done0, bus.err, bus.mul_en} !== 3'b110 || bus.result0 !== 16'h0) begin
      bad++; $display("FAIL timeout_flags got=%b r=%h exp=110 r=0000", {bus.done0, bus.err, bus.mul_en}, bus.result0);
    end
    bus.req0 = 0; hang = 0;
    @(negedge clk);
    total++;
    if (bus.err !== 1'b0) begin bad++; $display("FAIL timeout_err_pulse got=%b exp=0", bus.err); end
    m_last = 1'b0; m_r0 = 16'h0;
  endtask

  task automatic test_reset_mid_run();
    int n, en, fe;
    logic seen;
    logic [60:0] outs;
    hang = 1; lat = 2;
    bus.a0 = 8'd3; bus.b0 = 8'd3; bus.req0 = 1;
    repeat (6) @(negedge clk);
    total++;
    if ({bus.busy, bus.mul_en} !== 2'b11) begin bad++; $display("FAIL midrun_running got=%b exp=11", {bus.busy, bus.mul_en}); end
    #2 reset = 1'b1;
    #1 outs = {bus.done0, bus.done1, bus.err, bus.busy, bus.mul_en, bus.mul_a, bus.mul_b,
               bus.result0, bus.result1};
    total++;
    if (outs !== 61'd0) begin bad++; $display("FAIL midrun_async_reset got=%h exp=0", outs); end
    bus.req0 = 0; hang = 0;
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (4) begin @(negedge clk); seen = seen | bus.done0 | bus.done1 | bus.busy; end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL midrun_no_done got=%b exp=0", seen); end
    m_last = 1'b1; m_r0 = 16'h0; m_r1 = 16'h0;
    bus.a0 = 8'd9; bus.b0 = 8'd9; bus.req0 = 1;
    wait_done(n, en, fe);
    total++;
    if (n !== 5 || bus.done0 !== 1'b1 || bus.result0 !== 16'h0051) begin
      bad++; $display("FAIL midrun_after got=n%0d d0=%b r=%h exp=n5 d0=1 r=0051", n, bus.done0, bus.result0);
    end
    bus.req0 = 0;
    @(negedge clk);
    m_last = 1'b0; m_r0 = 16'h0051;
  endtask

  task automatic test_held_req();
    int n, en, fe;
    stale = 1; lat = 1;
    bus.a0 = 8'hFC; bus.b0 = 8'h7F; bus.req0 = 1;
    wait_done(n, en, fe);
    total++;
    if (n !== 4 || bus.result0 !== 16'hFE04) begin
      bad++; $display("FAIL held_first got=n%0d r=%h exp=n4 r=fe04", n, bus.result0);
    end
    bus.a0 = 8'h80; bus.b0 = 8'h80;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL held_idle_gap got=%b exp=0", bus.busy); end
    wait_done(n, en, fe);
    total++;
    if (n !== 4 || en !== 2 || bus.done0 !== 1'b1 || bus.result0 !== 16'h4000) begin
      bad++; $display("FAIL held_second got=n%0d en%0d d0=%b r=%h exp=n4 en2 d0=1 r=4000", n, en, bus.done0, bus.result0);
    end
    bus.req0 = 0; stale = 0;
    @(negedge clk);
    m_last = 1'b0; m_r0 = 16'h4000;
  endtask

  task automatic test_random();
    int n, en, fe, exp_n, exp_en;
    logic [1:0] pending;
    logic win;
    logic [15:0] exp_r;
    for (int it = 0; it < 24; it++) begin
      pending  = 2'($urandom_range(1, 3));
      lat      = int'($urandom_range(1, 5));
      hang     = ($urandom_range(0, 7) == 0);
      stale    = 1'($urandom_range(0, 1));
      bus.a0   = 8'($urandom); bus.b0 = 8'($urandom);
      bus.a1   = 8'($urandom); bus.b1 = 8'($urandom);
      bus.req0 = pending[0]; bus.req1 = pending[1];
      exp_en   = hang ? 32 : lat + 1;
      exp_n    = exp_en + 2;
      while (pending != 2'b00) begin
        wait_done(n, en, fe);
        win   = (pending == 2'b11) ? ~m_last : pending[1];
        exp_r = hang ? 16'h0 : (win ? prod(bus.a1, bus.b1) : prod(bus.a0, bus.b0));
        m_last = win;
        if (win) m_r1 = exp_r; else m_r0 = exp_r;
        total++;
        if (n !== exp_n || en !== exp_en || {bus.done1, bus.done0} !== (win ? 2'b10 : 2'b01) || bus.err !== hang) begin
          bad++;
          $display("FAIL rand_op it=%0d got=n%0d en%0d done=%b err=%b exp=n%0d en%0d port%0d err=%b",
                   it, n, en, {bus.done1, bus.done0}, bus.err, exp_n, exp_en, win, hang);
        end
        total++;
        if (bus.result0 !== m_r0 || bus.result1 !== m_r1) begin
          bad++; $display("FAIL rand_result it=%0d got=%h/%h exp=%h/%h", it, bus.result0, bus.result1, m_r0, m_r1);
        end
        pending[win] = 1'b0;
        if (win) bus.req1 = 0; else bus.req0 = 0;
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL rand_idle_gap it=%0d got=%b exp=0", it, bus.busy); end
      end
    end
    hang = 0; stale = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_signed();
    test_simultaneous();
    test_timeout();
    test_reset_mid_run();
    test_held_req();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
